pulse_gen_mc: RTL

Multi-channel random pulse generator, successor to the single-channel LFSR-threshold pulse generator. Each of P_N_CH channels compares a rotated slice of a shared random word against a programmable window, emits a pulse of programmable width followed by a programmable holdoff, and counts its pulses in a saturating counter. It sits between the 32-bit LFSR and the GPIO pulse outputs; the command/response controller drives the config and counter-readback ports.

---
 rtl/pulse_gen_pkg.sv | 18 +
 rtl/pulse_gen_ch.sv | 82 ++++++++
 rtl/pulse_gen_mc.sv | 85 ++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - config addresses, channel states and rotation helper for pulse_gen_mc
package pulse_gen_pkg;

  localparam logic [1:0] ADDR_X_LOW   = 2'd0;
  localparam logic [1:0] ADDR_X_HIGH  = 2'd1;
  localparam logic [1:0] ADDR_WIDTH   = 2'd2;
  localparam logic [1:0] ADDR_HOLDOFF = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Left-rotate amount applied to the shared random word for channel ch.
  function automatic int rot_amt(input int ch, input int xw, input int nch);
    return (ch * (xw / nch)) % xw;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// rtl/pulse_gen_ch.sv - one pulse channel: window regs, pulse/holdoff FSM, saturating counter
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int P_X_WIDTH   = 32,
  parameter int P_CNT_WIDTH = 32,
  parameter int P_TW_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_X_WIDTH-1:0]   x_ch,
  input  logic                   trig_en,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_addr,
  input  logic [P_X_WIDTH-1:0]   cfg_data,
  input  logic                   cnt_clr,
  output logic                   pulse,
  output logic [P_CNT_WIDTH-1:0] cnt
);

  logic [P_X_WIDTH-1:0]  x_low, x_high;
  logic [P_TW_WIDTH-1:0] width, holdoff, hold_len, timer;
  logic [1:0]            state;
  logic                  trig;

  assign trig = trig_en && (state == IDLE) && (x_ch >= x_low) && (x_ch < x_high);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_low   <= '0;
      x_high  <= '0;
      width   <= P_TW_WIDTH'(1);
      holdoff <= '0;
    end else if (cfg_wr) begin
      case (cfg_addr)
        ADDR_X_LOW:   x_low   <= cfg_data;
        ADDR_X_HIGH:  x_high  <= cfg_data;
        ADDR_WIDTH:   width   <= cfg_data[P_TW_WIDTH-1:0];
        default:      holdoff <= cfg_data[P_TW_WIDTH-1:0];
      endcase
    end
  end

  // timer holds remaining cycles minus one; width/holdoff are captured at trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      hold_len <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= (state == HIGH);
      case (state)
        IDLE: if (trig) begin
          state    <= HIGH;
          timer    <= (width == '0) ? '0 : width - 1'b1;
          hold_len <= holdoff;
        end
        HIGH: if (timer == '0) begin
          if (hold_len != '0) begin
            state <= HOLD;
            timer <= hold_len - 1'b1;
          end else begin
            state <= IDLE;
          end
        end else begin
          timer <= timer - 1'b1;
        end
        HOLD: if (timer == '0) state <= IDLE;
              else             timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (cnt_clr)           cnt <= '0;
    else if (trig && cnt != '1) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pulse_gen_mc.sv
// rtl/pulse_gen_mc.sv - multi-channel random pulse generator top
// Optional PULSE_GEN_GATE_EN adds a synchronised global trigger gate input.
module pulse_gen_mc
  import pulse_gen_pkg::*;
#(
  parameter int P_N_CH      = 4,
  parameter int P_X_WIDTH   = 32,
  parameter int P_CNT_WIDTH = 32,
  parameter int P_TW_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_X_WIDTH-1:0]   x,
  input  logic [P_N_CH-1:0]      ch_en,
`ifdef PULSE_GEN_GATE_EN
  input  logic                   gate,
`endif
  input  logic                   cfg_wr,
  input  logic [3:0]             cfg_ch,
  input  logic [1:0]             cfg_addr,
  input  logic [P_X_WIDTH-1:0]   cfg_data,
  input  logic [3:0]             cnt_sel,
  input  logic                   cnt_clr,
  output logic [P_N_CH-1:0]      pulse_out,
  output logic [P_CNT_WIDTH-1:0] cnt_out
);

  logic gate_ok;

`ifdef PULSE_GEN_GATE_EN
  logic gate_s1, gate_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_s1 <= 1'b0;
      gate_s2 <= 1'b0;
    end else begin
      gate_s1 <= gate;
      gate_s2 <= gate_s1;
    end
  end
  assign gate_ok = gate_s2;
`else
  assign gate_ok = 1'b1;
`endif

  logic [P_CNT_WIDTH-1:0] cnt_arr [P_N_CH];

  for (genvar ch = 0; ch < P_N_CH; ch++) begin : g_ch
    localparam int SH = rot_amt(ch, P_X_WIDTH, P_N_CH);
    logic [P_X_WIDTH-1:0] x_ch;
    assign x_ch = (x << SH) | (x >> ((P_X_WIDTH - SH) % P_X_WIDTH));

    pulse_gen_ch #(
      .P_X_WIDTH  (P_X_WIDTH),
      .P_CNT_WIDTH(P_CNT_WIDTH),
      .P_TW_WIDTH (P_TW_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .x_ch    (x_ch),
      .trig_en (ch_en[ch] && gate_ok),
      .cfg_wr  (cfg_wr && (cfg_ch == 4'(ch))),
      .cfg_addr(cfg_addr),
      .cfg_data(cfg_data),
      .cnt_clr (cnt_clr && (cnt_sel == 4'(ch))),
      .pulse   (pulse_out[ch]),
      .cnt     (cnt_arr[ch])
    );
  end

  // Out-of-range selects fall through to zero.
  logic [P_CNT_WIDTH-1:0] cnt_mux;
  always_comb begin
    cnt_mux = '0;
    for (int i = 0; i < P_N_CH; i++) begin
      if (cnt_sel == 4'(i)) cnt_mux = cnt_arr[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_out <= '0;
    else        cnt_out <= cnt_mux;
  end

endmodule
